regfile_sb: RTL and testbench

Parametrised multi-read-port register file with two write ports and a per-register pending-load scoreboard. It is the successor to the single-issue 32×32 MIPS register file in the CPU datapath: it sits between decode (reads, reservations) and the ALU/memory writeback stages. It answers "is this operand ready?" alongside its value, so decode can stall on load-use hazards without a separate hazard table.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 90 +++++++++
 tb/tb_regfile_sb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the register-address type for the regfile_sb slice.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load busy flags: load writeback clears a flag, reservation sets it and wins a tie.
// REGFILE_BYPASS_EN: a same-cycle clear shows up as not-busy on the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    output logic [NRD-1:0]        rd_busy,
    output logic                  err_spurious
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             wb_ok;
    logic             rsv_ok;

    assign wb_ok  = wb_en  && !(ZERO_REG != 0 && wb_addr  == '0);
    assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

    always_comb begin
        busy_nxt = busy;
        if (wb_ok)
            busy_nxt[wb_addr] = 1'b0;
        if (rsv_ok)
            busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            err_spurious <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (wb_ok && !busy[wb_addr])
                err_spurious <= 1'b1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [ADDR_W-1:0] a;
            assign a = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
            assign rd_busy[k] = busy[a] && !(wb_ok && wb_addr == a && !(rsv_ok && rsv_addr == a));
`else
            assign rd_busy[k] = busy[a];
`endif
        end
    endgenerate

endmodule

// File: rtl/regfile_sb.sv
// Multi-read register file, ALU (A) and load (B) write ports, pending-load scoreboard.
// REGFILE_BYPASS_EN: same-cycle write data forwarded to the read ports (A over B).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1,
    parameter int DBG_REG  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wa_en,
    input  logic [ADDR_W-1:0]     wa_addr,
    input  logic [DATA_W-1:0]     wa_data,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic [DATA_W-1:0]     zero_data,
    output logic                  err_spurious
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wa_ok;
    logic              wb_ok;

    assign wa_ok = wa_en && !(ZERO_REG != 0 && wa_addr == '0);
    assign wb_ok = wb_en && !(ZERO_REG != 0 && wb_addr == '0);

    // Port A is written last so it wins a same-address collision with B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wb_ok)
                mem[wb_addr] <= wb_data;
            if (wa_ok)
                mem[wa_addr] <= wa_data;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [ADDR_W-1:0] a;
            logic              zero_hit;
            assign a        = rd_addr[k*ADDR_W +: ADDR_W];
            assign zero_hit = (ZERO_REG != 0) && (a == '0);
`ifdef REGFILE_BYPASS_EN
            assign rd_data[k*DATA_W +: DATA_W] =
                zero_hit                   ? '0      :
                (wa_en && wa_addr == a)    ? wa_data :
                (wb_en && wb_addr == a)    ? wb_data : mem[a];
`else
            assign rd_data[k*DATA_W +: DATA_W] = zero_hit ? '0 : mem[a];
`endif
        end
    endgenerate

    assign dbg_data  = mem[DBG_IDX];
    assign zero_data = mem[0];

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .rd_busy      (rd_busy),
        .err_spurious (err_spurious)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios followed by random traffic.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    reg_addr_t   ra [2];
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wa_en = 1'b0, wb_en = 1'b0, rsv_en = 1'b0;
    reg_addr_t   wa_addr = '0, wb_addr = '0, rsv_addr = '0;
    logic [31:0] wa_data = '0, wb_data = '0;
    logic [31:0] dbg_data, zero_data;
    logic        err_spurious;

    assign rd_addr = {ra[1], ra[0]};

    regfile_sb dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .dbg_data(dbg_data), .zero_data(zero_data), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data [2];
        logic        busy [2];
        logic        err;
        logic [31:0] dbg;
        logic [31:0] zero;
        int          tag;
    } exp_t;

    exp_t        q [$];
    int          n_chk = 0, n_pass = 0, tag = 0;
    logic [31:0] m_reg  [32];
    bit          m_busy [32];
    bit          m_err;

    task automatic chk(string nm, int t, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s tag=%0d got=%h exp=%h", nm, t, act, exp);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
        m_err = 0;
    endfunction

    // Register 0 is hard-wired: nothing lands there, reads give 0 / not busy.
    function automatic exp_t predict();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            int a = int'(ra[k]);
            e.data[k] = (a == 0) ? 32'h0 : m_reg[a];
            e.busy[k] = (a != 0) && m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (a != 0) begin
                if (wa_en && int'(wa_addr) == a) e.data[k] = wa_data;
                else if (wb_en && int'(wb_addr) == a) e.data[k] = wb_data;
                if (wb_en && int'(wb_addr) == a && !(rsv_en && int'(rsv_addr) == a))
                    e.busy[k] = 0;
            end
`endif
        end
        e.err  = m_err;
        e.dbg  = m_reg[2];
        e.zero = 32'h0;
        e.tag  = tag;
        return e;
    endfunction

    function automatic void model_update();
        if (rst) begin model_clear(); return; end
        if (wb_en && wb_addr != 0) begin
            if (!m_busy[wb_addr]) m_err = 1;
            m_reg[wb_addr]  = wb_data;
            m_busy[wb_addr] = 0;
        end
        if (wa_en && wa_addr != 0) m_reg[wa_addr] = wa_data;
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
    endfunction

    // Called just after a rising edge: predict, wait the edge, advance model.
    task automatic cycle();
        q.push_back(predict());
        tag++;
        @(posedge clk);
        model_update();
        #1;
        wa_en = 0; wb_en = 0; rsv_en = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_clear();
        cycle();
        rst = 0;
    endtask

    task automatic rd(int a0, int a1);
        ra[0] = reg_addr_t'(a0);
        ra[1] = reg_addr_t'(a1);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rd_data%0d", k), e.tag, rd_data[k*32 +: 32], e.data[k]);
                chk($sformatf("rd_busy%0d", k), e.tag, 32'(rd_busy[k]), 32'(e.busy[k]));
            end
            chk("err_spurious", e.tag, 32'(err_spurious), 32'(e.err));
            chk("dbg_data", e.tag, dbg_data, e.dbg);
            chk("zero_data", e.tag, zero_data, e.zero);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog tag=%0d got=timeout exp=finish", tag);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        rd(5, 7);
        @(posedge clk); #1;
        cycle();                          // held in reset
        rst = 0;

        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 7;
        cycle();
        cycle();                          // r5 = DEADBEEF, r7 busy
        do_reset();                       // mid-run reset wipes both

        rd(3, 3);
        wa_en = 1; wa_addr = 3; wa_data = 32'h11; cycle();
        wa_en = 1; wa_addr = 3; wa_data = 32'h12345678; cycle();
        cycle();

        rd(9, 9);
        rsv_en = 1; rsv_addr = 9; cycle();
        wa_en = 1; wa_addr = 9; wa_data = 32'hAAAA0000;
        wb_en = 1; wb_addr = 9; wb_data = 32'h5555FFFF; cycle();
        cycle();

        rd(4, 9);
        rsv_en = 1; rsv_addr = 4; cycle();
        cycle();
        rsv_en = 1; rsv_addr = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h42; cycle();
        cycle();

        rd(0, 2);
        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 0; cycle();
        cycle();
        wa_en = 1; wa_addr = 2; wa_data = 32'd7; cycle();
        cycle();

        rd(6, 0);
        wb_en = 1; wb_addr = 6; wb_data = 32'h1; cycle();
        repeat (3) cycle();
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                continue;
            end
            wa_en    = ($urandom_range(0, 2) == 0);
            wa_addr  = reg_addr_t'($urandom_range(0, 15));
            wa_data  = $urandom;
            wb_en    = ($urandom_range(0, 3) == 0);
            wb_addr  = reg_addr_t'($urandom_range(0, 15));
            wb_data  = $urandom;
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = reg_addr_t'($urandom_range(0, 15));
            rd($urandom_range(0, 15), $urandom_range(0, 15));
            cycle();
        end

        @(posedge clk); #1;
        chk("queue_drained", tag, 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
